// File: rtl/sha256_msg_padder.sv
// Reads a message from word-addressed memory and presents it as SHA-256 padded 512-bit blocks
// over a valid/ready handshake, flagging the final block.
module sha256_msg_padder #(
  parameter int unsigned NUM_OF_WORDS = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [15:0]  message_addr,
  output logic         mem_clk,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  input  logic [31:0]  mem_read_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last,
  output logic         done
);

  localparam int unsigned NUM_BLOCKS = (NUM_OF_WORDS + 2) / 16 + 1;
  localparam int unsigned TotalWords = NUM_BLOCKS * 16;
  localparam logic [63:0] MsgBits    = 64'(NUM_OF_WORDS) * 64'd32;
  localparam logic [7:0]  LastBlk    = 8'(NUM_BLOCKS - 1);
  localparam logic [4:0]  FillEnd    = 5'd16;

  typedef enum logic [1:0] {StIdle, StFill, StOffer} state_e;

  state_e        state_q, state_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [7:0]    blk_q, blk_d;
  logic [4:0]    slot_q, slot_d;
  logic [511:0]  data_q, data_d;
  logic [31:0]   word_idx;
  logic [31:0]   word_val;

  // Word arriving this cycle belongs to the slot addressed on the previous cycle.
  assign word_idx = 32'({blk_q, 4'b0000}) + 32'(slot_q) - 32'd1;

  always_comb begin
    word_val = 32'h0;
    if (word_idx < NUM_OF_WORDS) begin
      word_val = mem_read_data;
    end else if (word_idx == NUM_OF_WORDS) begin
      word_val = 32'h8000_0000;
    end else if (word_idx == TotalWords - 2) begin
      word_val = MsgBits[63:32];
    end else if (word_idx == TotalWords - 1) begin
      word_val = MsgBits[31:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    blk_d      = blk_q;
    slot_d     = slot_q;
    data_d     = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mem_addr_d = message_addr;
          blk_d      = 8'd0;
          slot_d     = 5'd0;
          state_d    = StFill;
        end
      end
      StFill: begin
        // Address runs one ahead; after slot 15 it already points at the next block.
        if (slot_q != FillEnd) begin
          mem_addr_d = mem_addr_q + 16'd1;
        end
        if (slot_q != 5'd0) begin
          data_d = {data_q[479:0], word_val};
        end
        if (slot_q == FillEnd) begin
          slot_d  = 5'd0;
          state_d = StOffer;
        end else begin
          slot_d = slot_q + 5'd1;
        end
      end
      StOffer: begin
        if (blk_ready) begin
          if (blk_q == LastBlk) begin
            state_d = StIdle;
          end else begin
            blk_d   = blk_q + 8'd1;
            slot_d  = 5'd0;
            state_d = StFill;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      mem_addr_q <= 16'h0;
      blk_q      <= 8'd0;
      slot_q     <= 5'd0;
      data_q     <= 512'h0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      blk_q      <= blk_d;
      slot_q     <= slot_d;
      data_q     <= data_d;
    end
  end

  assign mem_clk   = clk;
  assign mem_we    = 1'b0;
  assign mem_addr  = mem_addr_q;
  assign blk_valid = (state_q == StOffer);
  assign blk_last  = (state_q == StOffer) && (blk_q == LastBlk);
  assign blk_data  = data_q;
  assign done      = (state_q == StIdle);

endmodule
